// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor and its companion checkers.
//   state_t       : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
//   sub_ovf()     : signed overflow of a - b from the operand and result MSBs
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Overflow of a subtraction: operands of opposite sign and a result whose
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb,
                                     input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit
//   bout out  borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = A - B - Bin, LSB first,
// one bit per clock. Operands are latched on an accepted start; results are
// held on diff/Bout/ovf until the next operation completes. WIDTH must be >= 2.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// SHIFT | processing one bit per cycle, WIDTH cycles
// DONE  | result valid, done pulses; start here is accepted back-to-back
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, sampled in IDLE or DONE only
//   A      in   minuend (signed), latched on accepted start
//   B      in   subtrahend (signed), latched on accepted start
//   Bin    in   borrow-in, latched on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when the result is valid
//   diff   out  A - B - Bin modulo 2^WIDTH
//   Bout   out  final borrow (unsigned A < unsigned B + Bin)
//   ovf    out  signed overflow
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   r_sr_q, r_sr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               fs_d;
    logic               fs_bout;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    a_sr_d  = A;
                    b_sr_d  = B;
                    br_d    = Bin;
                    r_sr_d  = '0;
                    cnt_d   = '0;
                    // The original MSBs are gone once the operands shift out.
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                r_sr_d = {fs_d, r_sr_q[WIDTH-1:1]};
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                br_d   = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // The last bit computed this cycle is the result MSB.
                    diff_d  = {fs_d, r_sr_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    ovf_d   = sub_ovf(a_msb_q, b_msb_q, fs_d);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign Bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver pushes the expected
// result of every accepted operation, a negedge monitor pops and compares on
// each done pulse and checks that outputs hold between results.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             Bout;
    logic             ovf;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rst_at_edge = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .Bout  (Bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc         = cyc + 1;
            rst_at_edge = rst_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from integer arithmetic on the operand values.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t e;
        int   sres;
        int   ua;
        int   ubb;
        int   lim;
        lim    = 1 << (WIDTH - 1);
        sres   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ua     = int'(a);
        ubb    = int'(b) + int'(bin);
        e.diff = sres[WIDTH-1:0];
        e.bout = (ua < ubb);
        e.ovf  = (sres < -lim) || (sres > lim - 1);
        e.cyc  = 0;
        return e;
    endfunction

    // Wait for the DUT to be able to accept, then present one start.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t e;
        int   budget;
        budget = 0;
        while (busy && budget < 40) begin
            @(posedge clk); #1;
            budget = budget + 1;
        end
        if (busy) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL accept_timeout: busy still %0b after %0d cycles", busy, budget);
        end
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        e     = model(a, b, bin);
        e.cyc = cyc + WIDTH + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t held;
        exp_t e;
        int   run;
        held.diff = '0;
        held.bout = 1'b0;
        held.ovf  = 1'b0;
        held.cyc  = 0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                held.diff = '0;
                held.bout = 1'b0;
                held.ovf  = 1'b0;
                run = 0;
            end else begin
                if (busy) run = run + 1;
                if (done) begin
                    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                    if (sb.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_done: done=%0b with no pending operation (cycle %0d)", done, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("diff", {24'd0, diff}, {24'd0, e.diff});
                        chk("bout", {31'd0, Bout}, {31'd0, e.bout});
                        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                        chk("latency_cycle", cyc, e.cyc);
                        chk("busy_cycles", run, WIDTH);
                        held = e;
                    end
                    run = 0;
                end else begin
                    chk("hold_diff", {24'd0, diff}, {24'd0, held.diff});
                    chk("hold_bout", {31'd0, Bout}, {31'd0, held.bout});
                    chk("hold_ovf", {31'd0, ovf}, {31'd0, held.ovf});
                end
            end
        end
    end

    // Driver
    initial begin
        int budget;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_diff", {24'd0, diff}, 32'd0);
        chk("reset_bout", {31'd0, Bout}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        issue(8'd23, 8'd12, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        issue(8'd12, 8'd23, 1'b0);
        issue(8'hF6, 8'd13, 1'b0);
        issue(8'h80, 8'd1, 1'b0);
        issue(8'd0, 8'd0, 1'b1);
        issue(8'd50, 8'd20, 1'b0);
        issue(8'h7F, 8'hFF, 1'b0);
        issue(8'h55, 8'h55, 1'b1);

        // A start during SHIFT must be ignored.
        issue(8'd7, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        A     = 8'd99;
        B     = 8'd1;
        Bin   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A     = 8'hAA;
        B     = 8'h11;
        repeat (12) @(posedge clk);
        #1;

        // Reset asserted during the 4th SHIFT cycle discards the operation.
        issue(8'd100, 8'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_diff", {24'd0, diff}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        issue(8'd60, 8'd70, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 1) begin
                repeat (gap + WIDTH) @(posedge clk);
                #1;
            end
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget = budget + 1;
        end
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
